// File: rtl/decode_pkg.sv
// Shared constants and the decoded-record type for the decode stage.
// Record widths are sized for the widest configuration; users slice to XLEN/PC_W.
package decode_pkg;

    localparam int MAX_XLEN = 64;
    localparam int MAX_PC_W = 64;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [MAX_PC_W-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [MAX_XLEN-1:0] imm;
        fmt_e                fmt;
        logic                rd_we;
        logic                illegal;
    } decoded_t;

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Both sides use valid/ready: a transfer happens on a clock edge where valid and ready are both 1.
interface decode_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_rd_we;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal
    );
endinterface

// File: rtl/decode_comb.sv
// Combinational RV32I/RV64I decoder: instruction word + PC -> decoded record.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int RV32E = 0
) (
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    output decoded_t        rec_o
);

    fmt_e        fmt;
    logic [63:0] imm_full;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        bad_reg;

    always_comb begin
        fmt = FMT_NONE;
        if (instr_i[1:0] == 2'b11) begin
            case (instr_i[6:0])
                OPC_OP:                                               fmt = FMT_R;
                OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: fmt = FMT_I;
                OPC_STORE:                                            fmt = FMT_S;
                OPC_BRANCH:                                           fmt = FMT_B;
                OPC_LUI, OPC_AUIPC:                                   fmt = FMT_U;
                OPC_JAL:                                              fmt = FMT_J;
                default:                                              fmt = FMT_NONE;
            endcase
        end
    end

    assign use_rd  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
    assign use_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    assign use_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

    // Immediates are sign-extended to 64 bits; the record is canonical for any XLEN.
    always_comb begin
        imm_full = '0;
        case (fmt)
            FMT_I: imm_full = {{52{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm_full = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm_full = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                               instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: imm_full = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
            FMT_J: imm_full = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                               instr_i[20], instr_i[30:21], 1'b0};
            default: imm_full = '0;
        endcase
    end

    assign bad_reg = (RV32E != 0) &&
                     ((use_rd && instr_i[11]) || (use_rs1 && instr_i[19]) || (use_rs2 && instr_i[24]));

    always_comb begin
        rec_o                = '0;
        rec_o.pc[PC_W-1:0]   = pc_i;
        rec_o.opcode         = instr_i[6:0];
        rec_o.fmt            = fmt;
        rec_o.rd             = use_rd  ? instr_i[11:7]  : 5'd0;
        rec_o.rs1            = use_rs1 ? instr_i[19:15] : 5'd0;
        rec_o.rs2            = use_rs2 ? instr_i[24:20] : 5'd0;
        rec_o.funct3         = use_rs1 ? instr_i[14:12] : 3'd0;
        rec_o.funct7         = (fmt == FMT_R) ? instr_i[31:25] : 7'd0;
        rec_o.imm            = (XLEN == 32) ? {{32{imm_full[31]}}, imm_full[31:0]} : imm_full;
        rec_o.illegal        = (fmt == FMT_NONE) || bad_reg;
        rec_o.rd_we          = use_rd && (instr_i[11:7] != 5'd0) &&
                               (instr_i[6:0] != OPC_MISC_MEM) && !rec_o.illegal;
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: decode_comb feeding a 2-entry registered output FIFO.
// Optional macro DECODE_PERF_CNT_EN adds decoded/illegal handshake counters.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int RV32E = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    decode_if.slave     bus
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0] perf_decoded,
    output logic [31:0] perf_illegal
`endif
);

    decoded_t   rec;
    decoded_t   head;
    decoded_t   mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push;
    logic       pop;
    logic       unused_head_bits;

    decode_comb #(.XLEN(XLEN), .PC_W(PC_W), .RV32E(RV32E)) u_comb (
        .instr_i (bus.in_instr),
        .pc_i    (bus.in_pc),
        .rec_o   (rec)
    );

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Flush wins over everything and rewinds the pointers with the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            if (push && !pop)      count_d = count_q + 2'd1;
            else if (pop && !push) count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush) mem_q[wr_ptr_q] <= rec;
        end
    end

    assign head             = mem_q[rd_ptr_q];
    assign unused_head_bits = ^{head.pc, head.imm};

    assign bus.out_pc      = head.pc[PC_W-1:0];
    assign bus.out_opcode  = head.opcode;
    assign bus.out_rd      = head.rd;
    assign bus.out_rs1     = head.rs1;
    assign bus.out_rs2     = head.rs2;
    assign bus.out_funct3  = head.funct3;
    assign bus.out_funct7  = head.funct7;
    assign bus.out_imm     = head.imm[XLEN-1:0];
    assign bus.out_fmt     = head.fmt;
    assign bus.out_rd_we   = head.rd_we;
    assign bus.out_illegal = head.illegal;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_decoded_q;
    logic [31:0] perf_illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded_q <= '0;
            perf_illegal_q <= '0;
        end else if (pop) begin
            perf_decoded_q <= perf_decoded_q + 32'd1;
            if (head.illegal) perf_illegal_q <= perf_illegal_q + 32'd1;
        end
    end

    assign perf_decoded = perf_decoded_q;
    assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed literal cases, backpressure, flush,
// async reset and randomized traffic against a queue-based reference model.
module tb_decode_stage;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            rd_we;
        logic            illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    decode_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_decoded;
    logic [31:0] perf_illegal;
`endif

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .RV32E(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
`ifdef DECODE_PERF_CNT_EN
        ,
        .perf_decoded (perf_decoded),
        .perf_illegal (perf_illegal)
`endif
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference decode written directly from the ISA field rules using arithmetic shifts.
    function automatic exp_t model(input logic [31:0] w, input logic [PC_W-1:0] pc);
        exp_t        e;
        longint      s;
        logic [63:0] imm64;
        bit          ur, u1, u2;
        s        = longint'($signed(w));
        e        = '{default: '0};
        e.pc     = pc;
        e.opcode = w[6:0];
        e.fmt    = 3'd7;
        case (w[6:0])
            7'b0110011:                                                 e.fmt = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: e.fmt = 3'd1;
            7'b0100011:                                                 e.fmt = 3'd2;
            7'b1100011:                                                 e.fmt = 3'd3;
            7'b0110111, 7'b0010111:                                     e.fmt = 3'd4;
            7'b1101111:                                                 e.fmt = 3'd5;
            default:                                                    e.fmt = 3'd7;
        endcase
        e.illegal = (e.fmt == 3'd7);
        ur = e.fmt inside {3'd0, 3'd1, 3'd4, 3'd5};
        u1 = e.fmt inside {3'd0, 3'd1, 3'd2, 3'd3};
        u2 = e.fmt inside {3'd0, 3'd2, 3'd3};
        e.rd  = ur ? w[11:7]  : 5'd0;
        e.rs1 = u1 ? w[19:15] : 5'd0;
        e.rs2 = u2 ? w[24:20] : 5'd0;
        e.f3  = u1 ? w[14:12] : 3'd0;
        e.f7  = (e.fmt == 3'd0) ? w[31:25] : 7'd0;
        case (e.fmt)
            3'd1:    imm64 = s >>> 20;
            3'd2:    imm64 = ((s >>> 25) << 5) | longint'(w[11:7]);
            3'd3:    imm64 = ((s >>> 31) << 12) | (longint'(w[7]) << 11) |
                             (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
            3'd4:    imm64 = (s >>> 12) << 12;
            3'd5:    imm64 = ((s >>> 31) << 20) | (longint'(w[19:12]) << 12) |
                             (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
            default: imm64 = 64'd0;
        endcase
        e.imm   = imm64[XLEN-1:0];
        e.rd_we = ur && (e.rd != 5'd0) && (w[6:0] != 7'b0001111) && !e.illegal;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                   7'b1110011, 7'b0001111, 7'b0100011, 7'b1100011,
                                   7'b0110111, 7'b0010111, 7'b1101111};
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 11);
        if (sel == 11) return r;
        return {r[31:7], opcs[sel]};
    endfunction

    task automatic compare_outputs();
        exp_t e;
        check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
        check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            check("out_pc", 64'(bus.out_pc), 64'(e.pc));
            check("out_imm", 64'(bus.out_imm), 64'(e.imm));
            check("out_fields",
                  64'({bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct3,
                       bus.out_funct7, bus.out_fmt, bus.out_rd_we, bus.out_illegal}),
                  64'({e.opcode, e.rd, e.rs1, e.rs2, e.f3, e.f7, e.fmt, e.rd_we, e.illegal}));
        end
    endtask

    task automatic model_edge(input logic v, input logic [31:0] instr, input logic [PC_W-1:0] pc,
                              input logic ordy, input logic fl);
        int n;
        bit do_push, do_pop;
        n       = exp_q.size();
        do_push = v && (n < 2);
        do_pop  = (n > 0) && ordy;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(model(instr, pc));
        end
    endtask

    // Called at a negedge: check current outputs, drive the next inputs, advance one cycle.
    task automatic step(input logic v, input logic [31:0] instr, input logic [PC_W-1:0] pc,
                        input logic ordy, input logic fl);
        compare_outputs();
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        model_edge(v, instr, pc, ordy, fl);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string n, input logic [2:0] fmt, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                       input logic [XLEN-1:0] imm, input logic rd_we, input logic ill);
        check({n, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({n, "_fmt"}, 64'(bus.out_fmt), 64'(fmt));
        check({n, "_regs"}, 64'({bus.out_rd, bus.out_rs1, bus.out_rs2}), 64'({rd, rs1, rs2}));
        check({n, "_funct7"}, 64'(bus.out_funct7), 64'(f7));
        check({n, "_imm"}, 64'(bus.out_imm), 64'(imm));
        check({n, "_we_ill"}, 64'({bus.out_rd_we, bus.out_illegal}), 64'({rd_we, ill}));
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_pc", 64'(bus.out_pc), 64'd0);
        check("rst_out_imm", 64'(bus.out_imm), 64'd0);
        check("rst_out_fields",
              64'({bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct3,
                   bus.out_funct7, bus.out_fmt, bus.out_rd_we, bus.out_illegal}), 64'd0);

        // Directed encodings with hand-computed expectations.
        step(1, 32'h00F502B3, 32'h100, 1, 0);
        lit("add", 3'd0, 5'd5, 5'd10, 5'd15, 7'd0, 32'h0, 1, 0);
        step(1, 32'hFFF50293, 32'h104, 1, 0);
        lit("addi", 3'd1, 5'd5, 5'd10, 5'd0, 7'd0, 32'hFFFFFFFF, 1, 0);
        step(1, 32'h00552423, 32'h108, 1, 0);
        lit("sw", 3'd2, 5'd0, 5'd10, 5'd5, 7'd0, 32'h8, 0, 0);
        step(1, 32'hFEA28EE3, 32'h10C, 1, 0);
        lit("beq", 3'd3, 5'd0, 5'd5, 5'd10, 7'd0, 32'hFFFFFFFC, 0, 0);
        step(1, 32'h123452B7, 32'h110, 1, 0);
        lit("lui", 3'd4, 5'd5, 5'd0, 5'd0, 7'd0, 32'h12345000, 1, 0);
        step(1, 32'h00000000, 32'h114, 1, 0);
        lit("zero_word", 3'd7, 5'd0, 5'd0, 5'd0, 7'd0, 32'h0, 0, 1);
        step(0, 32'h0, 32'h0, 1, 0);

        // Backpressure: third instruction is held until a slot frees.
        step(1, 32'h00F502B3, 32'h200, 0, 0);
        step(1, 32'hFFF50293, 32'h204, 0, 0);
        check("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
        step(1, 32'h123452B7, 32'h208, 0, 0);
        check("bp_head_held", 64'(bus.out_pc), 64'h200);
        step(1, 32'h123452B7, 32'h208, 1, 0);
        check("bp_drain_2nd", 64'({bus.out_valid, bus.out_pc}), 64'({1'b1, 32'h204}));
        step(1, 32'h123452B7, 32'h208, 1, 0);
        check("bp_drain_3rd", 64'({bus.out_valid, bus.out_pc}), 64'({1'b1, 32'h208}));
        step(0, 32'h0, 32'h0, 1, 0);
        check("bp_empty", 64'(bus.out_valid), 64'd0);

        // Flush with two buffered entries and a live input.
        step(1, 32'h00F502B3, 32'h300, 0, 0);
        step(1, 32'hFFF50293, 32'h304, 0, 0);
        step(1, 32'h123452B7, 32'h308, 1, 1);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_ready", 64'(bus.in_ready), 64'd1);
        step(0, 32'h0, 32'h0, 1, 0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end

        // Asynchronous reset between clock edges.
        step(1, rand_instr(), 32'h400, 0, 0);
        step(1, rand_instr(), 32'h404, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_pc", 64'(bus.out_pc), 64'd0);
        exp_q.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 1) != 0, rand_instr(), $urandom,
                 $urandom_range(0, 1) != 0, 1'b0);
        end
        compare_outputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined RV32I/RV64I instruction decode stage, the successor to the combinational field splitter.
- Sits between fetch and register-read/execute.
- Accepts {instruction, PC} over valid/ready. Extracts and zeroes fields by format, generates a sign-extended immediate, classifies the format, computes register write-enable and flags illegal encodings.
- Results are held in a 2-entry output buffer, so full throughput is sustained under backpressure.

Parameters:
- XLEN, 32, datapath width for out_imm (32 or 64).
- PC_W, 32, PC width, passed through unchanged.
- RV32E, 0, when 1 any used register index >= 16 sets out_illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered and incoming entries
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage can accept an entry (buffer not full)
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts the entry
- out_pc  out  PC_W  passed-through PC
- out_opcode  out  7  instr[6:0]
- out_rd / out_rs1 / out_rs2  out  5 each  register indices, 0 when not used by the format
- out_funct3  out  3  instr[14:12], 0 for U/J
- out_funct7  out  7  instr[31:25] for R-format, else 0
- out_imm  out  XLEN  sign-extended immediate, 0 for R-format
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, NONE=7
- out_rd_we  out  1  writes rd (format writes rd, rd!=0, not illegal)
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (async, rst_n=0): buffer empty; out_valid=0; in_ready=1 after release. All out_* data = 0.
- Opcode map:
  - 0110011 -> R.
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Anything else, or instr[1:0] != 2'b11 -> fmt=NONE, illegal=1, rd_we=0, all fields 0.
- Field use by format: rs2 used only by R/S/B; rs1 used by R/I/S/B; rd used by R/I/U/J. Unused fields are driven to 0.
- Immediates use the standard RISC-V bit scatter, sign-extended from instr[31] to XLEN. U-format: {instr[31:12], 12'b0}, sign-extended.
- rd_we exceptions: 0 for opcode 0001111 (fence); 0 when rd==0.
- Buffer: 2-entry FIFO of decoded records; in_ready = (count < 2), driven from registered state only.
  - Push on in_valid & in_ready; pop on out_valid & out_ready.
  - Latency 1 cycle: an entry accepted at edge N is presented on out_* from edge N onward with out_valid=1.
  - Outputs are registered and stable while out_valid & !out_ready.
- Simultaneous push and pop at count=1: count stays 1, new entry moves to head next cycle with no bubble.
- At count=2, no push occurs (in_ready=0); a pop that cycle frees a slot next cycle.
- Flush has priority over push and pop. Count goes to 0 at the edge; the same-cycle input is dropped, not counted, and any pop that cycle is discarded. Next cycle out_valid=0 and in_ready=1.
- Pointers wrap modulo 2. No data is lost or duplicated across wrap.
- Reset asserted mid-operation empties the buffer immediately, irrespective of clk.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- Defined: adds out ports perf_decoded[31:0] and perf_illegal[31:0].
  - perf_decoded increments on every out handshake; perf_illegal increments on out handshakes with out_illegal=1.
  - Both reset to 0, wrap at 2^32, and are not cleared by flush.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Package decode_pkg holds the opcode constants, the fmt encoding, and the decoded-record struct typedef (pc, opcode, rd, rs1, rs2, funct3, funct7, imm, fmt, rd_we, illegal).
- Sub-module decode_comb: purely combinational instruction -> record, carrying the RV32E and XLEN parameters.
- decode_stage instantiates decode_comb and owns the 2-entry buffer plus the optional counters.

Test Plan:
- add x5,x10,x15 (0x00F502B3), out_ready=1 -> next cycle: fmt=0, rd=5, rs1=10, rs2=15, funct7=0, imm=0, rd_we=1.
- addi x5,x10,-1 (0xFFF50293) -> fmt=1, rs2=0, imm=0xFFFFFFFF (XLEN=64: 0xFFFFFFFFFFFFFFFF), rd_we=1.
- sw x5,8(x10) (0x00552423), then beq x5,x10,-4 (0xFEA28EE3):
  - sw -> fmt=2, imm=8, rd=0, rd_we=0.
  - beq -> fmt=3, imm=0xFFFFFFFC.
- lui x5,0x12345 (0x123452B7) -> fmt=4, imm=0x12345000, rs1=0. Word 0x00000000 -> illegal=1, fmt=7, rd_we=0.
- Backpressure: out_ready=0 while pushing 3 instructions.
  - in_ready drops after the 2nd accept; the 3rd is held.
  - Raising out_ready drains all three in order with no bubble.
- Flush with 2 entries buffered and in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed and dropped entries never appear on out_*.
